// File: rtl/reg_file_bank_pkg.sv
// Shared types for the register bank: write-mode encoding and clear FSM states.
package reg_file_pkg;

  typedef enum logic [1:0] {
    WM_DATA   = 2'b00,
    WM_MOV_BA = 2'b01,
    WM_MOV_AB = 2'b10,
    WM_NOP    = 2'b11
  } wmode_e;

  localparam logic [0:0] CLR_IDLE = 1'b0;
  localparam logic [0:0] CLR_RUN  = 1'b1;

endpackage

// File: rtl/reg_file_bank_if.sv
// Decode/ALU-facing bus of the register bank; decode drives master, the bank is slave.
interface reg_file_bank_if #(
  parameter int W = 8,
  parameter int D = 4
) ();

  logic                 write_en;
  reg_file_pkg::wmode_e wmode;
  logic [D-1:0]         waddr;
  logic [D-1:0]         raddr_a;
  logic [D-1:0]         raddr_b;
  logic [W-1:0]         data_in;
  logic                 clear_req;
  logic [W-1:0]         data_out_a;
  logic [W-1:0]         data_out_b;
  logic                 busy;
  logic [2**D-1:0]      dirty;

  modport master (
    output write_en, wmode, waddr, raddr_a, raddr_b, data_in, clear_req,
    input  data_out_a, data_out_b, busy, dirty
  );

  modport slave (
    input  write_en, wmode, waddr, raddr_a, raddr_b, data_in, clear_req,
    output data_out_a, data_out_b, busy, dirty
  );

endinterface

// File: rtl/reg_file_bank_clear_seq.sv
// Clear sequencer: walks a counter over every register address, one per cycle.
module reg_clear_seq
  import reg_file_pkg::*;
#(
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_req,
  output logic         busy,
  output logic         clr_en,
  output logic [D-1:0] clr_addr
);

  logic [0:0]   state;
  logic [D-1:0] cnt;

  // A request arriving while already clearing is ignored; the walk is never restarted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clear_req) begin
            state <= CLR_RUN;
            cnt   <= '0;
          end
        end
        CLR_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= CLR_IDLE;
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

  assign busy     = (state == CLR_RUN);
  assign clr_en   = (state == CLR_RUN);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_bank.sv
// General-purpose register bank: two combinational reads, one write with bypass,
// register moves, optional zero register, dirty mask and a sequenced bank clear.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input logic            clk,
  input logic            rst,
  reg_file_bank_if.slave bus
);

  localparam int N = 2**D;

  logic [W-1:0] regs [N];
  logic [N-1:0] dirty;
  logic         busy;
  logic         clr_en;
  logic [D-1:0] clr_addr;
  logic         wr_hit;
  logic         wr_eff;
  logic [D-1:0] wr_dest;
  logic [W-1:0] wr_val;

  reg_clear_seq #(.D(D)) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // Moves take the source straight from the array so they copy the pre-edge value.
  always_comb begin
    wr_hit  = 1'b0;
    wr_dest = bus.waddr;
    wr_val  = bus.data_in;
    case (bus.wmode)
      WM_DATA: begin
        wr_hit  = 1'b1;
        wr_dest = bus.waddr;
        wr_val  = bus.data_in;
      end
      WM_MOV_BA: begin
        wr_hit  = 1'b1;
        wr_dest = bus.raddr_a;
        wr_val  = regs[bus.raddr_b];
      end
      WM_MOV_AB: begin
        wr_hit  = 1'b1;
        wr_dest = bus.raddr_b;
        wr_val  = regs[bus.raddr_a];
      end
      default: wr_hit = 1'b0;
    endcase
  end

  assign wr_eff = bus.write_en && wr_hit && !busy && !bus.clear_req &&
                  !(ZERO_R0 && (wr_dest == '0));

  assign bus.data_out_a = (ZERO_R0 && (bus.raddr_a == '0)) ? '0 :
                          (wr_eff && (wr_dest == bus.raddr_a)) ? wr_val :
                          regs[bus.raddr_a];
  assign bus.data_out_b = (ZERO_R0 && (bus.raddr_b == '0)) ? '0 :
                          (wr_eff && (wr_dest == bus.raddr_b)) ? wr_val :
                          regs[bus.raddr_b];

  assign bus.busy  = busy;
  assign bus.dirty = dirty;

  // The clear walk owns the array while busy; writes are only gated in otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      dirty <= '0;
    end else if (clr_en) begin
      regs[clr_addr]  <= '0;
      dirty[clr_addr] <= 1'b0;
    end else if (wr_eff) begin
      regs[wr_dest]  <= wr_val;
      dirty[wr_dest] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank with a scoreboard of expected values.
module tb_reg_file_bank;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  reg_file_bank_if #(.W(8), .D(4)) bus ();
  reg_file_bank_if #(.W(8), .D(4)) bus1 ();

  reg_file_bank #(.W(8), .D(4), .ZERO_R0(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reg_file_bank #(.W(8), .D(4), .ZERO_R0(1'b1)) u_dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input wmode_e m, input logic [3:0] wa,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [7:0] din, input logic clr);
    bus.write_en  = we;
    bus.wmode     = m;
    bus.waddr     = wa;
    bus.raddr_a   = ra;
    bus.raddr_b   = rb;
    bus.data_in   = din;
    bus.clear_req = clr;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (val_q.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    bus1.write_en  = 1'b0;
    bus1.wmode     = WM_DATA;
    bus1.waddr     = 4'd0;
    bus1.raddr_a   = 4'd0;
    bus1.raddr_b   = 4'd0;
    bus1.data_in   = 8'h00;
    bus1.clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    expectVal("reset_busy", 32'h0);   checkOutput(32'(bus.busy));
    expectVal("reset_dirty", 32'h0);  checkOutput(32'(bus.dirty));
    expectVal("reset_rd_a", 32'h0);   checkOutput(32'(bus.data_out_a));

    // Asynchronous reset mid-cycle must clear state without an edge.
    tick();
    applyStimulus(1'b1, WM_DATA, 4'd4, 4'd4, 4'd4, 8'h55, 1'b0);
    #3;
    expectVal("pre_rst_bypass", 32'h55); checkOutput(32'(bus.data_out_a));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd4, 4'd4, 8'h00, 1'b0);
    #2;
    expectVal("pre_rst_array", 32'h55);  checkOutput(32'(bus.data_out_a));
    rst = 1'b1;
    #1;
    expectVal("async_rst_rd_a", 32'h0);  checkOutput(32'(bus.data_out_a));
    expectVal("async_rst_rd_b", 32'h0);  checkOutput(32'(bus.data_out_b));
    expectVal("async_rst_dirty", 32'h0); checkOutput(32'(bus.dirty));
    expectVal("async_rst_busy", 32'h0);  checkOutput(32'(bus.busy));
    #1;
    rst = 1'b0;

    tick();
    applyStimulus(1'b1, WM_DATA, 4'd5, 4'd5, 4'd0, 8'hA7, 1'b0);
    #3;
    expectVal("data_bypass", 32'hA7);    checkOutput(32'(bus.data_out_a));
    expectVal("dirty_before", 32'h0);    checkOutput(32'(bus.dirty));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd5, 4'd0, 8'h00, 1'b0);
    #3;
    expectVal("data_array", 32'hA7);     checkOutput(32'(bus.data_out_a));
    expectVal("dirty_r5", 32'h0020);     checkOutput(32'(bus.dirty));

    tick();
    applyStimulus(1'b1, WM_DATA, 4'd3, 4'd0, 4'd0, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b1, WM_DATA, 4'd9, 4'd0, 4'd0, 8'h22, 1'b0);
    tick();
    applyStimulus(1'b1, WM_MOV_BA, 4'd0, 4'd3, 4'd9, 8'hFF, 1'b0);
    #3;
    expectVal("mov_ba_bypass", 32'h22);  checkOutput(32'(bus.data_out_a));
    expectVal("mov_ba_src", 32'h22);     checkOutput(32'(bus.data_out_b));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd3, 4'd9, 8'h00, 1'b0);
    #3;
    expectVal("mov_ba_r3", 32'h22);      checkOutput(32'(bus.data_out_a));
    tick();
    applyStimulus(1'b1, WM_MOV_AB, 4'd0, 4'd3, 4'd1, 8'hFF, 1'b0);
    #3;
    expectVal("mov_ab_bypass", 32'h22);  checkOutput(32'(bus.data_out_b));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd3, 4'd1, 8'h00, 1'b0);
    #3;
    expectVal("mov_ab_r1", 32'h22);      checkOutput(32'(bus.data_out_b));
    expectVal("dirty_moves", 32'h022A);  checkOutput(32'(bus.dirty));

    tick();
    applyStimulus(1'b1, WM_MOV_AB, 4'd0, 4'd7, 4'd7, 8'hFF, 1'b0);
    tick();
    applyStimulus(1'b1, WM_NOP, 4'd6, 4'd7, 4'd6, 8'h5A, 1'b0);
    #3;
    expectVal("self_move_r7", 32'h0);    checkOutput(32'(bus.data_out_a));
    expectVal("self_move_dirty", 32'h02AA); checkOutput(32'(bus.dirty));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd6, 4'd6, 8'h00, 1'b0);
    #3;
    expectVal("nop_r6", 32'h0);          checkOutput(32'(bus.data_out_a));
    expectVal("nop_dirty", 32'h02AA);    checkOutput(32'(bus.dirty));

    // Zero-register instance: r0 stays 0 and never becomes dirty.
    tick();
    bus1.write_en = 1'b1; bus1.wmode = WM_DATA; bus1.waddr = 4'd0;
    bus1.raddr_a = 4'd0; bus1.data_in = 8'hFF;
    #3;
    expectVal("z_r0_bypass", 32'h0);     checkOutput(32'(bus1.data_out_a));
    tick();
    bus1.write_en = 1'b0;
    #3;
    expectVal("z_r0_next", 32'h0);       checkOutput(32'(bus1.data_out_a));
    expectVal("z_dirty_r0", 32'h0);      checkOutput(32'(bus1.dirty));
    tick();
    bus1.write_en = 1'b1; bus1.waddr = 4'd2; bus1.raddr_a = 4'd2; bus1.data_in = 8'h3C;
    #3;
    expectVal("z_r2_bypass", 32'h3C);    checkOutput(32'(bus1.data_out_a));
    tick();
    bus1.write_en = 1'b0;
    #3;
    expectVal("z_dirty_r2", 32'h0004);   checkOutput(32'(bus1.dirty));

    for (int i = 0; i < 16; i++) begin
      tick();
      applyStimulus(1'b1, WM_DATA, 4'(i), 4'd0, 4'd0, 8'(8'h10 + i), 1'b0);
    end
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd0, 4'd15, 8'h00, 1'b0);
    #3;
    expectVal("fill_dirty", 32'hFFFF);   checkOutput(32'(bus.dirty));
    expectVal("fill_r15", 32'h1F);       checkOutput(32'(bus.data_out_b));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
    #3;
    expectVal("clr_req_busy", 32'h0);    checkOutput(32'(bus.busy));
    tick();

    // Busy window: write at i=3 must be dropped, re-request at i=10 ignored.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(logic'(i == 3), WM_DATA, 4'd2, (i == 3) ? 4'd2 : 4'd7, 4'd8,
                    8'hEE, logic'(i == 10));
      #3;
      expectVal("clr_busy_high", 32'h1); checkOutput(32'(bus.busy));
      if (i == 3) begin
        expectVal("clr_no_bypass", 32'h0); checkOutput(32'(bus.data_out_a));
      end
      if (i == 8) begin
        expectVal("clr_mid_r7", 32'h0);    checkOutput(32'(bus.data_out_a));
        expectVal("clr_mid_r8", 32'h18);   checkOutput(32'(bus.data_out_b));
      end
      tick();
    end
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    #3;
    expectVal("clr_busy_low", 32'h0);    checkOutput(32'(bus.busy));
    expectVal("clr_dirty", 32'h0);       checkOutput(32'(bus.dirty));
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, WM_DATA, 4'd0, 4'(i), 4'(15 - i), 8'h00, 1'b0);
      #1;
      expectVal("clr_all_zero", 32'h0);  checkOutput(32'(bus.data_out_a));
    end

    tick();
    applyStimulus(1'b1, WM_DATA, 4'd4, 4'd4, 4'd0, 8'h44, 1'b0);
    #3;
    expectVal("post_clr_bypass", 32'h44); checkOutput(32'(bus.data_out_a));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd4, 4'd0, 8'h00, 1'b0);
    #3;
    expectVal("post_clr_r4", 32'h44);    checkOutput(32'(bus.data_out_a));
    expectVal("post_clr_dirty", 32'h0010); checkOutput(32'(bus.dirty));

    tick();
    applyStimulus(1'b1, WM_DATA, 4'd2, 4'd2, 4'd2, 8'h99, 1'b1);
    #3;
    expectVal("clr_vs_write_rd", 32'h0); checkOutput(32'(bus.data_out_a));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd2, 4'd2, 8'h00, 1'b0);
    #3;
    expectVal("clr_vs_write_busy", 32'h1); checkOutput(32'(bus.busy));
    repeat (16) tick();
    #2;
    expectVal("clr2_busy_low", 32'h0);   checkOutput(32'(bus.busy));
    expectVal("clr_vs_write_r2", 32'h0); checkOutput(32'(bus.data_out_a));
    expectVal("clr2_dirty", 32'h0);      checkOutput(32'(bus.dirty));

    tick();
    applyStimulus(1'b1, WM_DATA, 4'd6, 4'd6, 4'd6, 8'h66, 1'b0);
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd6, 4'd6, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd6, 4'd6, 8'h00, 1'b0);
    repeat (5) tick();
    #2;
    expectVal("mid_clr_busy", 32'h1);    checkOutput(32'(bus.busy));
    expectVal("mid_clr_r6", 32'h66);     checkOutput(32'(bus.data_out_a));
    rst = 1'b1;
    #1;
    expectVal("mid_rst_busy", 32'h0);    checkOutput(32'(bus.busy));
    expectVal("mid_rst_r6", 32'h0);      checkOutput(32'(bus.data_out_a));
    expectVal("mid_rst_dirty", 32'h0);   checkOutput(32'(bus.dirty));
    #1;
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd6, 4'd6, 8'h00, 1'b1);
    #3;
    expectVal("reclr_req_busy", 32'h0);  checkOutput(32'(bus.busy));
    tick();
    applyStimulus(1'b0, WM_DATA, 4'd0, 4'd6, 4'd6, 8'h00, 1'b0);
    #3;
    expectVal("reclr_busy", 32'h1);      checkOutput(32'(bus.busy));
    repeat (16) tick();
    #2;
    expectVal("reclr_done", 32'h0);      checkOutput(32'(bus.busy));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised general-purpose register bank for the single-cycle datapath. It provides:
- two combinational read ports and one write port;
- same-cycle write-to-read bypass;
- register-to-register move modes;
- an optional hard-wired zero register;
- a per-register dirty mask;
- a multi-cycle clear sequencer with a busy flag.

It sits between instruction decode (addresses, write mode) and the ALU (operands in, result back).

## Interface
- W, default 8: data width.
- D, default 4: address width; depth is 2**D registers.
- ZERO_R0, default 0: when 1, register 0 always reads 0 and ignores all writes, including clear.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; zeroes all registers, Dirty, the FSM and the clear counter.
- WriteEn  in  1  write strobe for the current cycle.
- WMode  in  2  write mode: 00 DATA (Waddr ← DataIn), 01 MOV_BA (RaddrA ← reg[RaddrB]), 10 MOV_AB (RaddrB ← reg[RaddrA]), 11 NOP.
- Waddr  in  D  destination for DATA mode.
- RaddrA  in  D  read pointer A; also the move source/destination.
- RaddrB  in  D  read pointer B; also the move source/destination.
- DataIn  in  W  write data, used in DATA mode only.
- ClearReq  in  1  one-cycle request to clear the whole bank.
- DataOutA  out  W  combinational read A.
- DataOutB  out  W  combinational read B.
- Busy  out  1  high while the clear sequence runs.
- Dirty  out  2**D  bit i is set once register i has been written since the last reset or clear.

## Operation
- **Effective write.** A write is effective when WriteEn=1, Busy=0, ClearReq=0, WMode≠NOP, and the destination is not r0 with ZERO_R0=1.
- **Write commit.** An effective write commits at the edge and sets Dirty[dest].
- **Move source value.** A move copies the pre-edge source value.
- **Move onto itself.** A move where RaddrA==RaddrB is legal. The value is unchanged and the Dirty bit is still set.
- **Bypass.** When an effective write exists and its destination equals RaddrA or RaddrB, that read port returns the value being written instead of the array contents. For moves, the value being written is the source register value.
- **Zero register.** With ZERO_R0=1, reads of r0 return 0 regardless of bypass.
- **Clear FSM states:** IDLE and CLEAR.
  - IDLE → CLEAR when ClearReq=1. The counter is loaded with 0.
  - In CLEAR, reg[cnt] ← 0 and Dirty[cnt] ← 0 each cycle, then cnt increments.
  - CLEAR → IDLE after the cycle with cnt = 2**D−1. The counter wraps to 0.
- **ClearReq priority.** ClearReq has priority over a same-cycle write; that write is dropped.
- **ClearReq during CLEAR** is ignored. The sequence is not restarted.
- **Reads during CLEAR:**
  - return the current array contents: cleared entries read 0, uncleared entries read their old values;
  - bypass is inactive.
- **Reset mid-clear** returns the FSM to IDLE with Busy=0 and all registers 0.

## Timing
- **Reset values:** all registers 0, DataOutA/B = 0 (they follow the array), Busy=0, Dirty=0.
- **Read latency:** 0 cycles (combinational).
- **Write latency:** 1 edge. The value is visible through bypass in the same cycle and from the array in the next cycle.
- **Busy timing:** Busy rises in the cycle after ClearReq is sampled and stays high for exactly 2**D cycles (16 by default). The first accepted write is in the cycle Busy reads 0.
- **No stall from the block.** Upstream must hold or retry writes issued while Busy=1; the block never stalls them.

## Structure
- **Shared package reg_file_pkg:**
  - WMode enum: WM_DATA=2'b00, WM_MOV_BA=2'b01, WM_MOV_AB=2'b10, WM_NOP=2'b11;
  - clear FSM state enum: CLR_IDLE, CLR_RUN.
- **Sub-module reg_clear_seq** holds the FSM and D-bit counter.
  - Inputs: Clk, Reset, ClearReq.
  - Outputs: Busy, ClrEn, ClrAddr.
- **Top level** holds the storage array, write-mux, bypass and Dirty logic.

## Test plan
- **Reset:** assert Reset asynchronously mid-cycle → Busy=0, Dirty=0, all reads return 0 immediately, without waiting for an edge.
- **DATA write with bypass:** WriteEn=1, WMode=00, Waddr=5, DataIn=8'hA7, RaddrA=5 → DataOutA=8'hA7 in the same cycle. The next cycle, with WriteEn=0, DataOutA=8'hA7 and Dirty[5]=1.
- **Moves:**
  - r3=8'h11, r9=8'h22; MOV_BA with RaddrA=3, RaddrB=9 → after the edge r3=8'h22.
  - Then MOV_AB with RaddrA=3, RaddrB=1 → r1=8'h22.
- **Zero register:** ZERO_R0=1; DATA write to r0 with 8'hFF → DataOutA at r0 stays 0 in that cycle and the next, and Dirty[0]=0.
- **Clear sequence:**
  - Fill r0..r15 with 8'h10+i, then pulse ClearReq → Busy high for exactly 16 cycles.
  - Mid-sequence, at cycle 8 of Busy, r7=0 and r8=8'h18.
  - A write issued while Busy=1 is dropped.
  - Afterwards all registers read 0 and Dirty=0.
- **Simultaneous and mid-clear events:**
  - ClearReq in the same cycle as a DATA write to r2 → the write is dropped.
  - Reset asserted at Busy cycle 5 → Busy=0 on reset, and a new ClearReq is accepted afterwards.
